// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and bit-counter sizing.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One bit slice of a subtractor: d = a - b - br, built from two half-subtractors.
// Purely combinational, no backpressure.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic br_i,
  output logic d_o,
  output logic br_o
);

  logic d1;
  logic bo1;
  logic bo2;

  assign d1   = a_i ^ b_i;
  assign bo1  = ~a_i & b_i;
  assign d_o  = d1 ^ br_i;
  assign bo2  = ~d1 & br_i;
  assign br_o = bo1 | bo2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - b_in, LSB first; result valid WIDTH cycles after accept, held until out_ready.
// Single operation in flight (in_ready only in IDLE); SERIAL_SUB_OVF_EN adds the registered ovf output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             vld_q, vld_d;

  logic d_bit;
  logic br_nxt;
  logic last_bit;

  full_subtractor u_slice (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .br_i(br_q),
    .d_o (d_bit),
    .br_o(br_nxt)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = b_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands drain LSB first; each result bit enters at the MSB so bit 0 lands last in place.
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nxt;
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          cnt_d   = '0;
          bout_d  = br_nxt;
          vld_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      vld_q   <= vld_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: borrow into the MSB slice disagrees with the borrow out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last_bit) ovf_d = br_q ^ br_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = vld_q;
  assign diff      = diff_q;
  assign b_out     = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .b_out    (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    chk({tag, "_in_ready"}, in_ready, 1);
    a        = av;
    b        = bv;
    b_in     = bi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < WIDTH + 4) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, WIDTH);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo);
    accept(tag, av, bv, bi);
    wait_valid(tag);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, b_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation for %s", tag);
`endif
    drain(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_cnt;
    int bad;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    b_in      = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", b_out, 0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);

    run_op("op_5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("op_3m5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("op_0m0b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Output stalled with a new request pending: result must hold and nothing new may be accepted.
    accept("bp", 8'h20, 8'h07, 1'b0);
    wait_valid("bp");
    a        = 8'hAA;
    b        = 8'h11;
    b_in     = 1'b0;
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 5; i++) begin
      if (diff !== 8'h19 || b_out !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
      tick();
    end
    chk("bp_hold_violations", bad, 0);
    chk("bp_diff", diff, 8'h19);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_vld", out_valid, 0);
    chk("bp_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", in_ready, 0);
    wait_valid("bp2");
    chk("bp2_diff", diff, 8'h99);
    chk("bp2_bout", b_out, 0);
    drain("bp2");

    // Reset after bit 4 of an operation aborts it with no result.
    accept("rstrun", 8'h55, 8'h22, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("rstrun_busy", in_ready, 0);
    rst = 1'b1;
    #2;
    chk("rstrun_vld", out_valid, 0);
    chk("rstrun_diff", diff, 0);
    chk("rstrun_rdy", in_ready, 1);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("rstrun_no_pulse", bad, 0);
    run_op("op_10m1", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    // Consumer always ready: the result is visible for exactly one cycle.
    out_ready = 1'b1;
    accept("aready", 8'h40, 8'h01, 1'b0);
    hi_cnt = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      if (out_valid === 1'b1) begin
        hi_cnt++;
        chk("aready_diff", diff, 8'h3F);
      end
      tick();
    end
    out_ready = 1'b0;
    chk("aready_vld_cycles", hi_cnt, 1);

    run_op("ovf_80m1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_7Fm_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("ovf_5m3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor that computes A − B − borrow_in one bit per clock, LSB first, with a single borrow flip-flop between bit slices. It is the inverse-operation companion to the combinational adder cells in the arithmetic datapath. It suits area-constrained paths where WIDTH-cycle latency is acceptable. Operands enter and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 2
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- b_in  input  1  borrow into bit 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  difference, registered
- b_out  output  1  borrow out of MSB, registered
- ovf  output  1  signed overflow, registered; present only with SERIAL_SUB_OVF_EN

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE: in_ready=1. An input handshake (in_valid && in_ready) latches a, b, and b_in into the shift and borrow registers, clears the bit counter, and moves the block to RUN.
- RUN: each cycle computes bit i as d = a_i ^ b_i ^ br and next br = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d shifts into diff from the MSB side; the a and b shift registers shift right.
  - After bit WIDTH−1, the block moves to DONE and b_out takes the final borrow.
- DONE: out_valid=1; diff, b_out, and ovf are held stable. An output handshake (out_valid && out_ready) returns the block to IDLE.
- in_ready = (state==IDLE). No overlap between operations; in_valid is ignored in RUN and DONE.
- Arithmetic: diff = (a − b − b_in) mod 2^WIDTH. b_out=1 iff a < b + b_in, unsigned.
- Reset (async, any state): state=IDLE, diff=0, b_out=0, ovf=0, out_valid=0, counter=0, borrow=0. in_ready=1 once rst deasserts.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid pulse follows.
- Consumer holding out_ready=1 permanently: the result is still presented for exactly one cycle in DONE.

## Timing
- Input accept at edge E. Bits 0..WIDTH−1 are processed on edges E+1..E+WIDTH.
- out_valid is high from edge E+WIDTH until the output handshake edge.
- Minimum spacing between accepts is WIDTH+2 cycles (accept, WIDTH RUN cycles, one DONE cycle, return to IDLE).
- All outputs are registers, except in_ready, which is decoded from the state register.

## Configuration
- SERIAL_SUB_OVF_EN defined: the ovf port and its register exist. ovf = borrow into MSB slice XOR borrow out of MSB slice, captured with b_out.
- SERIAL_SUB_OVF_EN undefined: no ovf port and no extra logic. All other behaviour is identical.

## Structure
- Shared package serial_sub_pkg holds:
  - state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - counter width function $clog2(WIDTH)
- One sub-module, full_subtractor, computes one bit slice (a_i, b_i, br → d, br_next). It is built from two half-subtractor equations, mirroring the adder cell structure.
- The top level owns the FSM, counter, shift registers, and borrow flop.

## Test plan
- WIDTH=8, a=0x05, b=0x03, b_in=0 → diff=0x02, b_out=0; out_valid rises exactly 8 edges after accept.
- a=0x03, b=0x05, b_in=0 → diff=0xFE, b_out=1.
- a=0x00, b=0x00, b_in=1 → diff=0xFF, b_out=1.
- Result ready, out_ready held low 5 cycles with in_valid=1 throughout → diff/b_out stable, in_ready=0, no new accept. Accept occurs 2 cycles after out_ready rises.
- rst pulsed during RUN after bit 4 → out_valid=0, diff=0, in_ready=1. Next op a=0x10, b=0x01 → diff=0x0F, b_out=0.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 → diff=0x7F, b_out=0, ovf=1
  - a=0x7F, b=0xFF → diff=0x80, b_out=1, ovf=1
  - a=0x05, b=0x03 → ovf=0
